sram_model: RTL and testbench
=============================

SRAM_MODEL -- requirements
Module: sram_model

Interface
REQ-001 Parameter ADDR_W, default 17, address width in bits.
REQ-002 Parameter DATA_W, default 32, word width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W, number of stored words; legal range is 1 to 2**ADDR_W.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 Port SRAM_WE_N  input  1  write enable, active-low; 0 = write cycle, 1 = read cycle.
REQ-007 Port SRAM_ADDR  input  ADDR_W  word address.
REQ-008 Port SRAM_DQ  inout  DATA_W  bidirectional data bus, shared with the processor's memory stage.

Function
REQ-009 The block SHALL hold DEPTH words of DATA_W bits in an array addressed by word.
REQ-010 The effective index SHALL be SRAM_ADDR modulo DEPTH; out-of-range addresses wrap, with no error and no X.
REQ-011 Write: on a rising clk edge with reset=1 and SRAM_WE_N=0, mem[index] SHALL take the value of SRAM_DQ.
REQ-012 Read: on a rising clk edge with reset=1 and SRAM_WE_N=1, a registered read word rd_q SHALL load mem[index].
REQ-013 Write-through: on a write edge, rd_q SHALL load the written data.
REQ-014 Read latency SHALL be one clk edge: rd_q reflects the address presented before that edge.
REQ-015 With SRAM_WE_N=1, the block SHALL drive SRAM_DQ with rd_q.
REQ-016 With SRAM_WE_N=0, the block SHALL release SRAM_DQ to high-Z, so the processor is the only driver; the switch is combinational.
REQ-017 Consecutive writes to the same index SHALL keep the last value.
REQ-018 A read from an index never written SHALL return 0 (array zero-initialised at time 0).
REQ-019 SRAM_WE_N, SRAM_ADDR and SRAM_DQ SHALL be sampled only at rising clk edges.
REQ-020 The processor clock runs at 2x clk, and the processor holds each memory request stable for a full clk period; no handshake output exists.

Reset
REQ-021 When reset=0 at a rising clk edge, rd_q SHALL become 0 and no write SHALL occur, regardless of SRAM_WE_N.
REQ-022 Reset SHALL NOT clear the memory array; contents survive reset.
REQ-023 After reset deasserts, SRAM_DQ SHALL read 0 until the next read edge.
REQ-024 If reset asserts mid-burst, the write on that edge is dropped; earlier writes persist.

Structure
REQ-025 ADDR_W and DATA_W defaults SHALL live in the shared processor package, together with the memory base-address constant the processor uses for word addressing.
REQ-026 The block SHALL be a single module with no sub-modules.
REQ-027 The tri-state driver SHALL be one continuous assignment; the array and rd_q SHALL each have one clocked process.

Verification
REQ-028 Reset: hold reset=0 for 2 edges with WE_N=0, DQ=32'hFFFFFFFF, ADDR=0 -> then read ADDR 0 returns 0 and SRAM_DQ=0 immediately after reset.
REQ-029 Write/read: write 32'hDEADBEEF to ADDR 5 -> set WE_N=1 at ADDR 5 -> after one edge SRAM_DQ=32'hDEADBEEF.
REQ-030 Bus release: WE_N=0 -> SRAM_DQ is Z from the model; the bench drives 32'h12345678 with no contention (no X).
REQ-031 Wrap: with DEPTH=16, write 32'hA5A5A5A5 to ADDR 17 -> read ADDR 1 returns 32'hA5A5A5A5.
REQ-032 Overwrite and write-through: write 1 then 2 to ADDR 3 -> after switching WE_N=1 with no extra edge, SRAM_DQ=2.
REQ-033 Reset persistence: write 32'h0000_00FF to ADDR 100, pulse reset low for 1 edge, read ADDR 100 -> returns 32'h000000FF.

Source files
------------

// File: rtl/sram_model_pkg.sv
// Shared processor/memory constants: default SRAM geometry and the base address
// the memory stage subtracts before converting byte addresses to word addresses.
package sram_model_pkg;

  localparam int          SRAM_ADDR_W    = 17;
  localparam int          SRAM_DATA_W    = 32;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'h1000_0000;

  // Byte address in the processor map -> SRAM word address.
  function automatic logic [SRAM_ADDR_W-1:0] byte_to_word(input logic [31:0] byte_addr);
    return SRAM_ADDR_W'((byte_addr - SRAM_BASE_ADDR) >> 2);
  endfunction

endpackage

// File: rtl/sram_model_if.sv
// Control half of the SRAM bus. The data bus is bidirectional and stays a plain
// net between the processor and the model.
interface sram_model_if
  import sram_model_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) ();

  logic              SRAM_WE_N;
  logic [ADDR_W-1:0] SRAM_ADDR;

  modport master (output SRAM_WE_N, output SRAM_ADDR);
  modport slave  (input  SRAM_WE_N, input  SRAM_ADDR);

endinterface

// File: rtl/sram_model.sv
// Single-port synchronous SRAM behind a shared tri-state data bus: one-edge read
// latency, write-through on write edges, contents preserved across reset.
module sram_model
  import sram_model_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SRAM_WE_N,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W:0]   idx_full;
  logic [IDX_W-1:0]  idx;

  // One extra bit so DEPTH == 2**ADDR_W is representable as the divisor.
  assign idx_full = {1'b0, SRAM_ADDR} % (ADDR_W+1)'(DEPTH);
  assign idx      = idx_full[IDX_W-1:0];

  logic unused_idx_hi;
  assign unused_idx_hi = &{1'b0, idx_full[ADDR_W:IDX_W]};

  always_ff @(posedge clk) begin
    if (reset && !SRAM_WE_N) mem[idx] <= SRAM_DQ;
  end

  always_ff @(posedge clk) begin
    if (!reset)          rd_q <= '0;
    else if (!SRAM_WE_N) rd_q <= SRAM_DQ;
    else                 rd_q <= mem[idx];
  end

  // Released during writes so the processor is the sole driver.
  assign SRAM_DQ = SRAM_WE_N ? rd_q : 'z;

endmodule

// File: tb/tb_sram_model.sv
// Directed bench for sram_model with DEPTH=16 so address wrap is reachable.
module tb_sram_model;
  import sram_model_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              tb_oe;
  logic [DATA_W-1:0] tb_dq;
  wire  [DATA_W-1:0] dq;
  int                total = 0;
  int                bad   = 0;

  sram_model_if #(.ADDR_W(ADDR_W)) bus ();

  assign dq = tb_oe ? tb_dq : 'z;

  sram_model #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .SRAM_WE_N (bus.SRAM_WE_N),
    .SRAM_ADDR (bus.SRAM_ADDR),
    .SRAM_DQ   (dq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.SRAM_WE_N = 1'b0;
    bus.SRAM_ADDR = a;
    tb_oe         = 1'b1;
    tb_dq         = d;
    tick();
  endtask

  // Sets up a read cycle; the caller decides whether to take the edge.
  task automatic rd_setup(input logic [ADDR_W-1:0] a);
    tb_oe         = 1'b0;
    bus.SRAM_WE_N = 1'b1;
    bus.SRAM_ADDR = a;
    #1;
  endtask

  initial begin
    // Reset held two edges with a write pending: no write may land.
    reset = 1'b0; bus.SRAM_WE_N = 1'b0; bus.SRAM_ADDR = '0;
    tb_oe = 1'b1; tb_dq = 32'hFFFF_FFFF;
    tick(); tick();
    rd_setup(17'd0);
    chk("rst_rdq", dq, 32'h0);
    reset = 1'b1; #1;
    chk("post_rst_dq", dq, 32'h0);
    tick();
    chk("rd0_no_write_in_rst", dq, 32'h0);

    // Write then read back at address 5.
    wr(17'd5, 32'hDEAD_BEEF);
    rd_setup(17'd5);
    chk("wt_deadbeef", dq, 32'hDEAD_BEEF);
    tick();
    chk("rd5", dq, 32'hDEAD_BEEF);

    // Bus release: the bench is the only driver during a write.
    bus.SRAM_WE_N = 1'b0; bus.SRAM_ADDR = 17'd7; tb_oe = 1'b1; tb_dq = 32'h1234_5678; #1;
    chk("release", dq, 32'h1234_5678);
    tick();
    rd_setup(17'd0); tick();
    chk("rd0_again", dq, 32'h0);
    rd_setup(17'd7); tick();
    chk("rd7", dq, 32'h1234_5678);

    // Wrap: address 17 aliases index 1.
    wr(17'd17, 32'hA5A5_A5A5);
    rd_setup(17'd5); tick();
    chk("rd5_between", dq, 32'hDEAD_BEEF);
    rd_setup(17'd1); tick();
    chk("wrap_rd1", dq, 32'hA5A5_A5A5);

    // Overwrite keeps the last value; write-through visible without another edge.
    wr(17'd3, 32'h1);
    wr(17'd3, 32'h2);
    rd_setup(17'd3);
    chk("wt_overwrite", dq, 32'h2);
    rd_setup(17'd9); tick();
    chk("rd9_unwritten", dq, 32'h0);
    rd_setup(17'd3); tick();
    chk("rd3_last", dq, 32'h2);

    // Contents survive reset; the write on the reset edge is dropped.
    wr(17'd100, 32'h0000_00FF);
    reset = 1'b0;
    wr(17'd100, 32'h0000_0BAD);
    reset = 1'b1;
    rd_setup(17'd100);
    chk("rst_clears_rdq", dq, 32'h0);
    tick();
    chk("persist_100", dq, 32'h0000_00FF);
    rd_setup(17'd5); tick();
    chk("persist_5", dq, 32'hDEAD_BEEF);
    rd_setup(17'd116); tick();
    chk("wrap_rd116", dq, 32'h0000_00FF);

    // Address change alone must not affect the bus before an edge.
    rd_setup(17'd5);
    chk("latency_hold", dq, 32'h0000_00FF);
    tick();
    chk("latency_update", dq, 32'hDEAD_BEEF);

    chk("byte_to_word", 32'(byte_to_word(SRAM_BASE_ADDR + 32'h14)), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish");
    $fatal(1, "timeout");
  end

endmodule
